// File: rtl/secuenciador_if_pkg.sv
// Shared definitions for the IF-stage sequencer: widths, HALT encoding and FSM state codes.
// Also reused by the debug unit so both sides agree on the encodings.
package secuenciador_if_pkg;

  localparam int RAM_WIDTH_PROGRAMA = 32;
  localparam int CANT_BITS_ADDR     = 11;
  localparam int RAM_DEPTH_PROGRAMA = 2048;
  localparam int CANT_BITS_CICLOS   = 16;
  localparam logic [RAM_WIDTH_PROGRAMA-1:0] HALT_WORD = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    READY  = 3'd3,
    RUN    = 3'd4,
    STEP   = 3'd5,
    HALTED = 3'd6
  } estado_t;

  function automatic logic es_halt(input logic [RAM_WIDTH_PROGRAMA-1:0] palabra);
    return palabra == HALT_WORD;
  endfunction

endpackage

// File: rtl/secuenciador_if_if.sv
// Debug-unit / program-memory bundle around the IF sequencer.
// o_checksum exists only when IF_SEQ_CHECKSUM_EN is defined.
interface secuenciador_if_if;
  import secuenciador_if_pkg::*;

  logic                          i_load_start;
  logic                          i_instr_valid;
  logic [RAM_WIDTH_PROGRAMA-1:0] i_instr_data;
  logic                          o_instr_ready;
  logic                          i_run;
  logic                          i_step;
  logic [RAM_WIDTH_PROGRAMA-1:0] i_instruction;
  logic                          o_enable_mem;
  logic                          o_write_read_mem;
  logic                          o_control_mux_addr_mem;
  logic [CANT_BITS_ADDR-1:0]     o_addr_mem_programa;
  logic [RAM_WIDTH_PROGRAMA-1:0] o_data_mem_programa;
  logic                          o_enable_contador_PC;
  logic [2:0]                    o_estado;
  logic                          o_halted;
  logic                          o_error_overflow;
  logic [CANT_BITS_ADDR:0]       o_cant_instr;
  logic [CANT_BITS_CICLOS-1:0]   o_cant_ciclos;
`ifdef IF_SEQ_CHECKSUM_EN
  logic [RAM_WIDTH_PROGRAMA-1:0] o_checksum;
`endif

  modport master (
    output i_load_start, i_instr_valid, i_instr_data, i_run, i_step, i_instruction,
    input  o_instr_ready, o_enable_mem, o_write_read_mem, o_control_mux_addr_mem,
    input  o_addr_mem_programa, o_data_mem_programa, o_enable_contador_PC, o_estado,
    input  o_halted, o_error_overflow, o_cant_instr, o_cant_ciclos
`ifdef IF_SEQ_CHECKSUM_EN
    , input o_checksum
`endif
  );

  modport slave (
    input  i_load_start, i_instr_valid, i_instr_data, i_run, i_step, i_instruction,
    output o_instr_ready, o_enable_mem, o_write_read_mem, o_control_mux_addr_mem,
    output o_addr_mem_programa, o_data_mem_programa, o_enable_contador_PC, o_estado,
    output o_halted, o_error_overflow, o_cant_instr, o_cant_ciclos
`ifdef IF_SEQ_CHECKSUM_EN
    , output o_checksum
`endif
  );

endinterface

// File: rtl/secuenciador_if_contador_saturado.sv
// Saturating enable counter with synchronous clear; clear has priority over enable.
module contador_saturado #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_cuenta
);

  always_ff @(posedge i_clock) begin
    if (i_clear)
      o_cuenta <= '0;
    else if (i_enable && (o_cuenta != '1))
      o_cuenta <= o_cuenta + WIDTH'(1);
  end

endmodule

// File: rtl/secuenciador_if.sv
// IF-stage sequencer: loads program memory from the debug unit, then gates the PC for run/step.
// Optional IF_SEQ_CHECKSUM_EN adds a running XOR of the words written in the current load.
//
// state  | meaning
// IDLE   | after reset, waiting for a load request
// LOAD   | ready for the next instruction word
// WRITE  | one-cycle write of the latched word
// READY  | program loaded, waiting for run or step
// RUN    | PC advances every cycle until HALT is fetched
// STEP   | single fetch, then back to READY
// HALTED | HALT fetched; only a new load or reset leaves
module secuenciador_if
  import secuenciador_if_pkg::*;
(
  input logic              i_clock,
  input logic              i_soft_reset,
  secuenciador_if_if.slave bus
);

  localparam logic [CANT_BITS_ADDR-1:0] ADDR_ULTIMA = CANT_BITS_ADDR'(RAM_DEPTH_PROGRAMA - 1);

  estado_t                       estado;
  logic [CANT_BITS_ADDR-1:0]     addr;
  logic [RAM_WIDTH_PROGRAMA-1:0] dato;
  logic [CANT_BITS_ADDR:0]       cant_instr;
  logic                          instr_ready, write_read, control_mux, halted, overflow;
  logic                          halt_fetch, dato_halt, fin_carga, enable_pc, clear_ciclos;
`ifdef IF_SEQ_CHECKSUM_EN
  logic [RAM_WIDTH_PROGRAMA-1:0] checksum;
`endif

  assign halt_fetch = es_halt(bus.i_instruction);
  assign dato_halt  = es_halt(dato);
  // The address never wraps: writing the last word ends the load even without HALT.
  assign fin_carga  = dato_halt || (addr == ADDR_ULTIMA);
  assign enable_pc  = ((estado == RUN) || (estado == STEP)) && !halt_fetch;
  assign clear_ciclos = !i_soft_reset
                     || ((estado == WRITE) && fin_carga)
                     || ((estado == STEP) && !halt_fetch);

  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      estado      <= IDLE;
      addr        <= '0;
      dato        <= '0;
      cant_instr  <= '0;
      instr_ready <= 1'b0;
      write_read  <= 1'b0;
      control_mux <= 1'b0;
      halted      <= 1'b0;
      overflow    <= 1'b0;
`ifdef IF_SEQ_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      case (estado)
        IDLE, READY, HALTED: begin
          if (bus.i_load_start) begin
            estado      <= LOAD;
            addr        <= '0;
            cant_instr  <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
            control_mux <= 1'b1;
            instr_ready <= 1'b1;
`ifdef IF_SEQ_CHECKSUM_EN
            checksum    <= '0;
`endif
          end else if (estado == READY) begin
            if (bus.i_run)
              estado <= RUN;
            else if (bus.i_step)
              estado <= STEP;
          end
        end
        LOAD: begin
          if (bus.i_instr_valid) begin
            dato        <= bus.i_instr_data;
            estado      <= WRITE;
            instr_ready <= 1'b0;
            write_read  <= 1'b1;
          end
        end
        WRITE: begin
          write_read <= 1'b0;
          cant_instr <= cant_instr + 1'b1;
`ifdef IF_SEQ_CHECKSUM_EN
          checksum   <= checksum ^ dato;
`endif
          if (fin_carga) begin
            estado      <= READY;
            control_mux <= 1'b0;
            overflow    <= !dato_halt;
          end else begin
            addr        <= addr + 1'b1;
            estado      <= LOAD;
            instr_ready <= 1'b1;
          end
        end
        RUN: begin
          if (halt_fetch) begin
            estado <= HALTED;
            halted <= 1'b1;
          end
        end
        STEP: begin
          if (halt_fetch) begin
            estado <= HALTED;
            halted <= 1'b1;
          end else begin
            estado <= READY;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

  contador_saturado #(.WIDTH(CANT_BITS_CICLOS)) u_contador_ciclos (
    .i_clock  (i_clock),
    .i_clear  (clear_ciclos),
    .i_enable (enable_pc),
    .o_cuenta (bus.o_cant_ciclos)
  );

  assign bus.o_instr_ready          = instr_ready;
  assign bus.o_enable_mem           = 1'b1;
  assign bus.o_write_read_mem       = write_read;
  assign bus.o_control_mux_addr_mem = control_mux;
  assign bus.o_addr_mem_programa    = addr;
  assign bus.o_data_mem_programa    = dato;
  assign bus.o_enable_contador_PC   = enable_pc;
  assign bus.o_estado               = estado;
  assign bus.o_halted               = halted;
  assign bus.o_error_overflow       = overflow;
  assign bus.o_cant_instr           = cant_instr;
`ifdef IF_SEQ_CHECKSUM_EN
  assign bus.o_checksum             = checksum;
`endif

endmodule
